// File: rtl/dig_ct_pipe.sv
// dig_ct_pipe: CH independent channels of a runtime-programmable two-stage
// bitwise function R = f_OP2(f_OP1(A, B), C). Each result is followed by
// PIPE register stages with valid tracking, a global hold and a saturating
// count of delivered valid results.
//
// Ports:
//   CLK       rising-edge clock
//   RST_N     asynchronous active-low reset
//   IN_A/B/C  operands, channel k at [k*WIDTH +: WIDTH]
//   IN_VALID  operands valid this cycle
//   HOLD      freeze pipeline (data and valid) and counter
//   CFG_WE    config write strobe (accepted regardless of HOLD)
//   CFG_CH    channel to configure; out-of-range writes are ignored
//   CFG_OP    {OP2[5:3], OP1[2:0]}
//   OUT       last pipeline stage data, same packing as operands
//   OUT_VALID last pipeline stage valid
//   VAL_CNT   saturating count of valid results loaded into the last stage
module dig_ct_pipe #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CH    = 3,
    parameter int unsigned PIPE  = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic                                  CLK,
    input  logic                                  RST_N,
    input  logic [CH*WIDTH-1:0]                   IN_A,
    input  logic [CH*WIDTH-1:0]                   IN_B,
    input  logic [CH*WIDTH-1:0]                   IN_C,
    input  logic                                  IN_VALID,
    input  logic                                  HOLD,
    input  logic                                  CFG_WE,
    input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] CFG_CH,
    input  logic [5:0]                            CFG_OP,
    output logic [CH*WIDTH-1:0]                   OUT,
    output logic                                  OUT_VALID,
    output logic [CNT_W-1:0]                      VAL_CNT
);

    localparam int unsigned CW        = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned DW        = CH * WIDTH;
    localparam logic [5:0]  CFG_RESET = 6'b010_011;  // OP2=NAND, OP1=NOR
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Bitwise op selected by a 3-bit code.
    function automatic logic [WIDTH-1:0] bitop(input logic [2:0] op,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    r = x & y;
            3'd1:    r = x | y;
            3'd2:    r = ~(x & y);
            3'd3:    r = ~(x | y);
            3'd4:    r = x ^ y;
            3'd5:    r = ~(x ^ y);
            3'd6:    r = x & ~y;
            default: r = x | ~y;
        endcase
        return r;
    endfunction

    logic [5:0]       cfg_q  [CH];
    logic [WIDTH-1:0] s1_c   [CH];
    logic [DW-1:0]    res_c;
    logic [DW-1:0]    data_q [PIPE];
    logic [PIPE-1:0]  vld_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_vld_nxt_c;

    // Per-channel config registers; writes to channels >= CH match no k.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < CH; k++) cfg_q[k] <= CFG_RESET;
        end else begin
            for (int k = 0; k < CH; k++) begin
                if (CFG_WE && (CFG_CH == CW'(k))) cfg_q[k] <= CFG_OP;
            end
        end
    end

    // Two-stage function per channel, on the current (old) config.
    always_comb begin
        res_c = '0;
        for (int k = 0; k < CH; k++) begin
            s1_c[k] = bitop(cfg_q[k][2:0], IN_A[k*WIDTH +: WIDTH], IN_B[k*WIDTH +: WIDTH]);
            res_c[k*WIDTH +: WIDTH] = bitop(cfg_q[k][5:3], s1_c[k], IN_C[k*WIDTH +: WIDTH]);
        end
    end

    // Valid bit that the next non-held edge will load into the last stage.
    if (PIPE == 1) begin : g_last_p1
        assign last_vld_nxt_c = IN_VALID;
    end else begin : g_last_pn
        assign last_vld_nxt_c = vld_q[PIPE-2];
    end

    // Data/valid shift pipeline; HOLD freezes every stage.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < PIPE; i++) data_q[i] <= '0;
            vld_q <= '0;
        end else if (!HOLD) begin
            data_q[0] <= res_c;
            vld_q[0]  <= IN_VALID;
            for (int i = 1; i < PIPE; i++) begin
                data_q[i] <= data_q[i-1];
                vld_q[i]  <= vld_q[i-1];
            end
        end
    end

    // Saturating count of valid results reaching the output.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else if (!HOLD && last_vld_nxt_c && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign OUT       = data_q[PIPE-1];
    assign OUT_VALID = vld_q[PIPE-1];
    assign VAL_CNT   = cnt_q;

endmodule

// File: tb/tb_dig_ct_pipe.sv
// Self-checking bench for dig_ct_pipe (WIDTH=4, CH=3, PIPE=2, CNT_W=4).
// The reference model keeps a history of samples taken on non-held edges
// and evaluates each op from its truth table.
module tb_dig_ct_pipe;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CH    = 3;
    localparam int unsigned PIPE  = 2;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DW    = CH * WIDTH;
    localparam int unsigned SAT   = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic [DW-1:0]    IN_A, IN_B, IN_C;
    logic             IN_VALID, HOLD, CFG_WE;
    logic [1:0]       CFG_CH;
    logic [5:0]       CFG_OP;
    logic [DW-1:0]    OUT;
    logic             OUT_VALID;
    logic [CNT_W-1:0] VAL_CNT;

    dig_ct_pipe #(.WIDTH(WIDTH), .CH(CH), .PIPE(PIPE), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_A(IN_A), .IN_B(IN_B), .IN_C(IN_C),
        .IN_VALID(IN_VALID), .HOLD(HOLD), .CFG_WE(CFG_WE), .CFG_CH(CFG_CH),
        .CFG_OP(CFG_OP), .OUT(OUT), .OUT_VALID(OUT_VALID), .VAL_CNT(VAL_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] d;
        logic          v;
    } sample_t;

    sample_t     hist[$];   // hist[0] = newest accepted sample
    logic [5:0]  mcfg [CH];
    int unsigned mcnt;
    int          n_assert = 0;
    int          n_fail   = 0;

    // Truth table per op, indexed by {x,y}.
    function automatic logic [WIDTH-1:0] fop(input logic [2:0] op,
                                             input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
        logic [3:0]       tt;
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b0111;
            3'd3:    tt = 4'b0001;
            3'd4:    tt = 4'b0110;
            3'd5:    tt = 4'b1001;
            3'd6:    tt = 4'b0100;
            default: tt = 4'b1101;
        endcase
        for (int i = 0; i < WIDTH; i++) r[i] = tt[{x[i], y[i]}];
        return r;
    endfunction

    function automatic logic [DW-1:0] model_res(input logic [DW-1:0] a,
                                                input logic [DW-1:0] b,
                                                input logic [DW-1:0] c);
        logic [DW-1:0]    r;
        logic [WIDTH-1:0] s1;
        for (int k = 0; k < CH; k++) begin
            s1 = fop(mcfg[k][2:0], a[k*WIDTH +: WIDTH], b[k*WIDTH +: WIDTH]);
            r[k*WIDTH +: WIDTH] = fop(mcfg[k][5:3], s1, c[k*WIDTH +: WIDTH]);
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < CH; k++) mcfg[k] = 6'b010_011;
        hist.delete();
        for (int i = 0; i < PIPE; i++) hist.push_back('{d: '0, v: 1'b0});
        mcnt = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_out"},   32'(OUT),       32'(hist[PIPE-1].d));
        check({tag, "_valid"}, 32'(OUT_VALID), 32'(hist[PIPE-1].v));
        check({tag, "_cnt"},   32'(VAL_CNT),   32'(mcnt));
    endtask

    // Drive one cycle, advance the model at the edge, check #1 later.
    task automatic cycle(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input logic v, input logic h,
                         input logic we, input logic [1:0] ch, input logic [5:0] op,
                         input string tag);
        logic [DW-1:0] res;
        IN_A = a; IN_B = b; IN_C = c; IN_VALID = v; HOLD = h;
        CFG_WE = we; CFG_CH = ch; CFG_OP = op;
        @(posedge CLK);
        res = model_res(a, b, c);
        if (!h) begin
            hist.push_front('{d: res, v: v});
            void'(hist.pop_back());
            if (hist[PIPE-1].v && mcnt < SAT) mcnt++;
        end
        if (we && 32'(ch) < CH) mcfg[ch] = op;
        #1;
        check_model(tag);
    endtask

    task automatic idle(input string tag);
        cycle('0, '0, '0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, tag);
    endtask

    function automatic logic [DW-1:0] rnd();
        return DW'($urandom);
    endfunction

    initial begin
        int unsigned cnt_before;
        RST_N = 1'b0; IN_A = '0; IN_B = '0; IN_C = '0; IN_VALID = 1'b0;
        HOLD = 1'b0; CFG_WE = 1'b0; CFG_CH = '0; CFG_OP = '0;
        model_reset();
        #12;
        check("rst_out",   32'(OUT),       32'd0);
        check("rst_valid", 32'(OUT_VALID), 32'd0);
        check("rst_cnt",   32'(VAL_CNT),   32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // Default NOR/NAND on ch0: NOR(0001,0000)=1110, NAND(1110,1111)=0001.
        cycle(12'h001, 12'h000, 12'h00F, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0, "t1_in");
        idle("t1_lat");
        check("t1_out0",  32'(OUT[3:0]),  32'h1);
        check("t1_valid", 32'(OUT_VALID), 32'd1);
        check("t1_cnt",   32'(VAL_CNT),   32'd1);
        idle("t1_drain");

        // ch1: OP1=XOR, OP2=AND -> (1010^0110)&1100 = 1100.
        cycle('0, '0, '0, 1'b0, 1'b0, 1'b1, 2'd1, 6'b000_100, "t2_cfg");
        cycle(12'h0A0, 12'h060, 12'h0C0, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0, "t2_in");
        idle("t2_lat");
        check("t2_out1", 32'(OUT[7:4]), 32'hC);

        // Same-edge write to ch2 (OP1=OR, OP2=AND): first sample uses old config.
        cycle(12'h300, 12'h400, 12'hF00, 1'b1, 1'b0, 1'b1, 2'd2, 6'b000_001, "t3_in0");
        cycle(12'h300, 12'h400, 12'hF00, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0, "t3_in1");
        check("t3_old", 32'(OUT[11:8]), 32'h7);
        cycle(12'h300, 12'h400, 12'h000, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0, "t3_in2");
        check("t3_new", 32'(OUT[11:8]), 32'h7);
        idle("t3_lat");
        check("t3_newc0", 32'(OUT[11:8]), 32'h0);
        idle("t3_drain");

        // HOLD with two results in flight.
        cycle(rnd(), rnd(), rnd(), 1'b1, 1'b0, 1'b0, 2'd0, 6'd0, "t4_r1");
        cycle(rnd(), rnd(), rnd(), 1'b1, 1'b0, 1'b0, 2'd0, 6'd0, "t4_r2");
        cnt_before = mcnt;
        repeat (3) cycle(rnd(), rnd(), rnd(), 1'b1, 1'b1, 1'b0, 2'd0, 6'd0, "t4_hold");
        check("t4_hold_valid", 32'(OUT_VALID), 32'd1);
        check("t4_hold_cnt",   32'(VAL_CNT),   32'(cnt_before));
        idle("t4_rel1");
        idle("t4_rel2");
        check("t4_no_dup", 32'(OUT_VALID), 32'd0);

        // Counter saturation.
        repeat (20) cycle(rnd(), rnd(), rnd(), 1'b1, 1'b0, 1'b0, 2'd0, 6'd0, "t5_stream");
        check("t5_sat", 32'(VAL_CNT), 32'(SAT));
        idle("t5_sat_hold");
        check("t5_sat2", 32'(VAL_CNT), 32'(SAT));

        // Asynchronous reset between edges, mid-stream.
        cycle(rnd(), rnd(), rnd(), 1'b1, 1'b0, 1'b1, 2'd0, 6'b000_000, "t6_pre");
        #4;
        RST_N = 1'b0;
        model_reset();
        #1;
        check("t6_out",   32'(OUT),       32'd0);
        check("t6_valid", 32'(OUT_VALID), 32'd0);
        check("t6_cnt",   32'(VAL_CNT),   32'd0);
        RST_N = 1'b1;
        cycle('0, '0, '0, 1'b0, 1'b0, 1'b1, 2'd3, 6'b000_000, "t6_badcfg");
        cycle(12'h000, 12'h000, 12'h000, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0, "t6_in");
        idle("t6_lat");
        check("t6_cfgdef", 32'(OUT), 32'hFFF);

        // Randomized traffic with holds and config writes.
        for (int i = 0; i < 300; i++) begin
            cycle(rnd(), rnd(), rnd(), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0),
                  2'($urandom_range(0, 3)), 6'($urandom), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
